// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op encodings driven on mdu_iterative.op
//   - FSM state type
//   - iteration counter width helper
package mdu_pkg;

   localparam logic [1:0] OP_MUL   = 2'b00;  // low half of A*B
   localparam logic [1:0] OP_MULHU = 2'b01;  // high half of A*B
   localparam logic [1:0] OP_DIVU  = 2'b10;  // A / B
   localparam logic [1:0] OP_REMU  = 2'b11;  // A % B

   typedef enum logic [2:0] {
      StIdle,
      StMul,
      StDiv,
      StWrite,
      StFin
   } mdu_state_e;

   // Counter must be able to hold DATA_WIDTH itself.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// A single adder is shared: it adds B for shift-add multiply and subtracts B
// (via inverted operand and carry-in) for restoring division.
//   is_div  in   0: multiply step, 1: divide step
//   acc_hi  in   hi (multiply) or partial remainder R (divide), DATA_WIDTH+1 bits
//   acc_lo  in   lo (multiply) or quotient Q (divide)
//   b       in   multiplicand / divisor
//   nxt_hi  out  next hi / R
//   nxt_lo  out  next lo / Q
module mdu_step #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  is_div,
   input  logic [DATA_WIDTH:0]   acc_hi,
   input  logic [DATA_WIDTH-1:0] acc_lo,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH:0]   nxt_hi,
   output logic [DATA_WIDTH-1:0] nxt_lo
);

   localparam int unsigned W = DATA_WIDTH;

   logic [W:0]   opa;
   logic [W+1:0] opb;
   logic         cin;
   logic [W+1:0] sum;
   logic [W:0]   mul_src;

   // R never exceeds the divisor, so its top bit is always zero before the shift.
   logic unused_r_msb;
   assign unused_r_msb = acc_hi[W];

   always_comb begin
      if (is_div) begin
         opa = {acc_hi[W-1:0], acc_lo[W-1]};  // {R,Q} << 1, upper part
         opb = ~{2'b00, b};
         cin = 1'b1;
      end else begin
         opa = {1'b0, acc_hi[W-1:0]};
         opb = {2'b00, b};
         cin = 1'b0;
      end
      sum = {1'b0, opa} + opb + {{(W + 1){1'b0}}, cin};

      mul_src = acc_lo[0] ? sum[W:0] : opa;

      if (is_div) begin
         // sum[W+1] set means the trial subtraction went negative: restore.
         if (!sum[W+1]) begin
            nxt_hi = sum[W:0];
            nxt_lo = {acc_lo[W-2:0], 1'b1};
         end else begin
            nxt_hi = opa;
            nxt_lo = {acc_lo[W-2:0], 1'b0};
         end
      end else begin
         nxt_hi = {1'b0, mul_src[W:1]};
         nxt_lo = {mul_src[0], acc_lo[W-1:1]};
      end
   end

endmodule

// File: rtl/mdu_iterative.sv
// Iterative unsigned multiply/divide unit writing back through the
// register_file write port.
//   clk, rst_n         clock, asynchronous active-low reset
//   start, op          request (sampled only when idle) and operation
//   rs1_data, rs2_data operand A / dividend, operand B / divisor
//   rd_addr            destination register (0 means no write-back)
//   busy, done         busy from accept to done; done is a one-cycle pulse
//   wr_en, wr_addr,
//   wr_data, wr_ack    register_file write handshake
module mdu_iterative
   import mdu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [DATA_WIDTH-1:0] rs1_data,
   input  logic [DATA_WIDTH-1:0] rs2_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_ack
);

   localparam int unsigned CntW = cnt_width(DATA_WIDTH);

   mdu_state_e            state_q, state_d;
   logic [1:0]            op_q, op_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [DATA_WIDTH:0]   hi_q, hi_d;
   logic [DATA_WIDTH-1:0] lo_q, lo_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

   logic [DATA_WIDTH:0]   step_hi;
   logic [DATA_WIDTH-1:0] step_lo;
   logic [DATA_WIDTH-1:0] result;

   mdu_step #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_step (
      .is_div(op_q[1]),
      .acc_hi(hi_q),
      .acc_lo(lo_q),
      .b     (b_q),
      .nxt_hi(step_hi),
      .nxt_lo(step_lo)
   );

   // Result of the final iteration, latched into wr_data on the last step.
   always_comb begin
      case (op_q)
         OP_MUL:   result = step_lo;
         OP_MULHU: result = step_hi[DATA_WIDTH-1:0];
         OP_DIVU:  result = step_lo;
         default:  result = step_hi[DATA_WIDTH-1:0];
      endcase
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      b_d       = b_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      cnt_d     = cnt_q;
      wr_data_d = wr_data_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               op_d   = op;
               addr_d = rd_addr;
               b_d    = rs2_data;
               lo_d   = rs1_data;
               hi_d   = '0;
               cnt_d  = CntW'(DATA_WIDTH);
               if (op[1] && (rs2_data == '0)) begin
                  // Divide by zero: quotient all-ones, remainder = dividend.
                  wr_data_d = op[0] ? rs1_data : '1;
                  state_d   = (rd_addr == '0) ? StFin : StWrite;
               end else begin
                  state_d = op[1] ? StDiv : StMul;
               end
            end
         end
         StMul, StDiv: begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
               wr_data_d = result;
               state_d   = (addr_q == '0) ? StFin : StWrite;
            end
         end
         StWrite: begin
            if (wr_ack) state_d = StFin;
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         op_q      <= '0;
         addr_q    <= '0;
         b_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         cnt_q     <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         b_q       <= b_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         cnt_q     <= cnt_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Outputs decode directly from state so an async reset clears them at once.
   assign busy    = (state_q != StIdle);
   assign done    = (state_q == StFin);
   assign wr_en   = (state_q == StWrite);
   assign wr_addr = addr_q;
   assign wr_data = wr_data_q;

endmodule

// File: tb/tb_mdu_iterative.sv
module tb_mdu_iterative;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    op = 2'b00;
   logic [DW-1:0] rs1_data = '0;
   logic [DW-1:0] rs2_data = '0;
   logic [AW-1:0] rd_addr = '0;
   logic          busy, done, wr_en, wr_ack;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   logic          ack_q;
   logic          ack_force = 1'b0;
   logic [DW-1:0] rf [32] = '{default: '0};
   int            wr_total = 0;
   int            done_total = 0;
   int            n_assert = 0;
   int            n_fail = 0;

   always #5 clk = ~clk;

   mdu_iterative #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .rs1_data(rs1_data),
      .rs2_data(rs2_data),
      .rd_addr (rd_addr),
      .busy    (busy),
      .done    (done),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_ack  (wr_ack)
   );

   // Register file model: writes on wr_en, acknowledges one edge later.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ack_q <= 1'b0;
      else begin
         ack_q <= wr_en;
         if (wr_en) rf[wr_addr] <= wr_data;
      end
   end
   assign wr_ack = ack_q | ack_force;

   always @(posedge clk) begin
      if (wr_en) wr_total++;
      if (done) done_total++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] ref_result(input logic [1:0] o, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
      logic [2*DW-1:0] p;
      p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      case (o)
         2'd0:    return p[DW-1:0];
         2'd1:    return p[2*DW-1:DW];
         2'd2:    return (b == '0) ? '1 : a / b;
         default: return (b == '0) ? a : a % b;
      endcase
   endfunction

   // Issue one operation, optionally poke start/wr_ack while busy at cycle
   // 'glitch', then check latency, write count, done count and write-back.
   task automatic run_op(input logic [1:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [AW-1:0] rd, input int glitch);
      logic [DW-1:0] exp;
      logic [DW-1:0] r0_before;
      int            exp_lat;
      int            k;
      int            w0;
      int            d0;
      bit            seen;
      exp     = ref_result(o, a, b);
      exp_lat = (o[1] && b == '0) ? 3 : DW + 3;
      if (rd == '0) exp_lat -= 2;
      r0_before = rf[0];
      @(negedge clk);
      start    = 1'b1;
      op       = o;
      rs1_data = a;
      rs2_data = b;
      rd_addr  = rd;
      w0       = wr_total;
      d0       = done_total;
      @(posedge clk);
      #1;
      start    = 1'b0;
      op       = 2'($urandom);
      rs1_data = $urandom;
      rs2_data = $urandom;
      rd_addr  = AW'($urandom);
      check("busy_after_accept", 64'(busy), 64'(1));
      seen = done;
      k    = 0;
      while (!seen && k < 60) begin
         if (glitch != 0 && k == glitch) begin
            start     = 1'b1;
            op        = 2'b00;
            ack_force = 1'b1;
         end else begin
            start     = 1'b0;
            ack_force = 1'b0;
         end
         @(posedge clk);
         #1;
         k++;
         if (wr_en) begin
            check("wr_data", 64'(wr_data), 64'(exp));
            check("wr_addr", 64'(wr_addr), 64'(rd));
         end
         if (done) seen = 1'b1;
      end
      start     = 1'b0;
      ack_force = 1'b0;
      check("done_seen", 64'(seen), 64'(1));
      check("latency", 64'(k + 1), 64'(exp_lat));
      @(posedge clk);
      #1;
      check("busy_drop", 64'(busy), 64'(0));
      check("wr_cycles", 64'(wr_total - w0), 64'((rd == '0) ? 0 : 2));
      check("done_pulses", 64'(done_total - d0), 64'(1));
      if (rd != '0) check("rf_value", 64'(rf[rd]), 64'(exp));
      else check("rf0_unchanged", 64'(rf[0]), 64'(r0_before));
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_done"}, 64'(done), 64'(0));
      check({tag, "_wr_en"}, 64'(wr_en), 64'(0));
      check({tag, "_wr_addr"}, 64'(wr_addr), 64'(0));
      check({tag, "_wr_data"}, 64'(wr_data), 64'(0));
   endtask

   initial begin
      logic [1:0]    ro;
      logic [DW-1:0] ra;
      logic [DW-1:0] rb;
      logic [DW-1:0] r7_before;
      int            w0;

      #12;
      check_idle_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      run_op(2'b00, 32'd7, 32'd6, 5'd3, 0);
      check("mul_7x6", 64'(rf[3]), 64'(42));
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0);
      check("mulhu_max", 64'(rf[4]), 64'hFFFF_FFFE);
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 0);
      check("mul_max", 64'(rf[8]), 64'h1);
      run_op(2'b10, 32'd100, 32'd7, 5'd9, 0);
      check("divu_100_7", 64'(rf[9]), 64'd14);
      run_op(2'b11, 32'd100, 32'd7, 5'd10, 0);
      check("remu_100_7", 64'(rf[10]), 64'd2);
      run_op(2'b10, 32'd5, 32'd0, 5'd11, 0);
      check("divu_by_zero", 64'(rf[11]), 64'hFFFF_FFFF);
      run_op(2'b11, 32'd5, 32'd0, 5'd12, 0);
      check("remu_by_zero", 64'(rf[12]), 64'd5);
      run_op(2'b00, 32'd3, 32'd3, 5'd0, 0);
      run_op(2'b10, 32'd0, 32'd0, 5'd0, 0);

      // Start (and a stray wr_ack) while busy must be ignored; the next op is
      // issued on the first idle cycle.
      run_op(2'b10, 32'd1000, 32'd33, 5'd13, 10);
      run_op(2'b00, 32'd12345, 32'd678, 5'd14, 0);

      // Asynchronous reset in the middle of a multiply.
      r7_before = rf[7];
      @(negedge clk);
      start    = 1'b1;
      op       = 2'b00;
      rs1_data = 32'd11;
      rs2_data = 32'd13;
      rd_addr  = 5'd7;
      w0       = wr_total;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #2;
      check("pre_reset_busy", 64'(busy), 64'(1));
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midop_reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("reset_no_write", 64'(wr_total - w0), 64'(0));
      check("reset_rf7", 64'(rf[7]), 64'(r7_before));
      check("reset_idle", 64'(busy), 64'(0));
      run_op(2'b00, 32'd2, 32'd2, 5'd5, 0);
      check("mul_after_reset", 64'(rf[5]), 64'd4);

      // Random operations against the arithmetic reference model.
      for (int i = 0; i < 14; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = '0;
            1:       rb = DW'($urandom_range(1, 15));
            2:       ra = DW'($urandom_range(0, 255));
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 5) != 0) rb = (rb == '0 && $urandom_range(0, 1) == 0) ? rb : $urandom;
         run_op(ro, ra, rb, AW'($urandom_range(0, 31)), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mdu_iterative.md
# mdu_iterative

Iterative multiply/divide unit sitting directly downstream of `register_file`. It consumes the two read ports (`rd_data1`, `rd_data2`), computes one of four unsigned multiply/divide results over `DATA_WIDTH` cycles, then writes the result back through the register file write port, holding the write until `wr_ack` returns. It replaces a combinational multiplier/divider on the datapath with a bounded-latency, single-adder sequential core.

## Interface

- `DATA_WIDTH`, 32, operand and result width.
- `ADDR_WIDTH`, 5, register address width; must match `register_file`.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  2  00 MUL (low half), 01 MULHU (high half), 10 DIVU, 11 REMU.
- `rs1_data`  in  DATA_WIDTH  operand A / dividend (from `rd_data1`).
- `rs2_data`  in  DATA_WIDTH  operand B / divisor (from `rd_data2`).
- `rd_addr`  in  ADDR_WIDTH  destination register.
- `busy`  out  1  high from accept until `done`.
- `done`  out  1  one-cycle completion pulse.
- `wr_en`  out  1  to `register_file.wr_en`.
- `wr_addr`  out  ADDR_WIDTH  to `register_file.wr_addr`.
- `wr_data`  out  DATA_WIDTH  to `register_file.wr_data`.
- `wr_ack`  in  1  from `register_file.wr_ack`.

## Operation

- States: IDLE, MUL, DIV, WRITE, FIN.
- IDLE: on `start`=1, capture `op`, operands, `rd_addr` into internal registers. Load counter to `DATA_WIDTH`. Go to MUL (op[1]=0) or DIV (op[1]=1).
- Divisor zero on DIVU/REMU: skip DIV, go straight to WRITE. Result is quotient all-ones or remainder = dividend.
- MUL: shift-add over a 2·`DATA_WIDTH` accumulator {hi, lo}, with lo initialised to A. Each cycle, if lo[0] then hi += B, with carry kept in a (`DATA_WIDTH`+1)-bit sum. The accumulator then shifts right 1. The counter decrements; at 0, go to WRITE.
- DIV: restoring division. The partial remainder R is `DATA_WIDTH`+1 bits and Q is loaded with the dividend. Each cycle, {R,Q} shifts left 1 and trial = R − divisor. If trial ≥ 0, R = trial and Q[0] = 1. At counter 0, go to WRITE.
- Result select: MUL → lo, MULHU → hi, DIVU → Q, REMU → R[`DATA_WIDTH`-1:0].
- WRITE: `wr_en`=1 with `wr_addr`/`wr_data` stable. On a cycle where `wr_ack`=1, go to FIN.
  - If the captured `rd_addr`=0, WRITE is bypassed straight to FIN with no `wr_en`. Register 0 is never written.
- FIN: `done`=1 for one cycle, then `busy`=0 and return to IDLE.
- `start` while `busy`=1 is ignored; it is not queued.
- Operand inputs may change freely after accept.

## Timing

- Reset (async, `rst_n`=0): state IDLE. `busy`, `done`, `wr_en` = 0; `wr_addr`, `wr_data` = 0; counter and datapath registers = 0.
- Reset mid-operation aborts immediately with no write. After release the unit is idle.
- Accept at edge E0 (`start`=1, `busy`=0). `busy`=1 after E0.
- Iterations run on edges E1…E`DATA_WIDTH`. `wr_en` rises after E`DATA_WIDTH`.
- `register_file` registers `wr_ack` one edge after seeing `wr_en`. The typical sequence is:
  - `wr_en` is high for 2 cycles (a harmless double write of identical data).
  - FIN follows for 1 cycle.
  - Total start-to-`done` latency is `DATA_WIDTH`+3 cycles (35 at default).
- Divide-by-zero latency is 3 cycles. The `rd_addr`=0 bypass removes the 2 write cycles.
- `busy` falls the edge after `done`. Back-to-back: `start` may be accepted in the first cycle `busy`=0.
- `wr_ack` that is asserted while not in WRITE is ignored.

## Structure

- Package `mdu_pkg`:
  - op encoding constants `OP_MUL`, `OP_MULHU`, `OP_DIVU`, `OP_REMU`;
  - state enum;
  - counter width `$clog2(DATA_WIDTH+1)`.
- One combinational sub-module, `mdu_step`. It takes the mode, the current {hi/R, lo/Q} and B, and produces the next accumulator. This keeps the single shared adder/subtractor out of the FSM.
- The FSM, counter and write-back handshake stay in `mdu_iterative`.

## Test plan

- MUL 7×6, rd_addr=3 → after 35 cycles register 3 = 42; `done` pulses once; `wr_en` high exactly 2 cycles.
- MULHU 0xFFFFFFFF×0xFFFFFFFF, rd_addr=4 → register 4 = 0xFFFFFFFE. Check MUL on the same operands: 0x00000001.
- DIVU 100/7 → 14 and REMU 100/7 → 2. DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with 3-cycle latency.
- rd_addr=0 with MUL 3×3 → no `wr_en` ever; `done` pulses; register 0 unchanged.
- `start` pulsed at cycle 10 of a running DIVU → ignored; exactly one write and one `done`. A second `start` on the first idle cycle is accepted.
- `rst_n` low at cycle 20 of MUL → outputs 0 asynchronously, no write. A new MUL 2×2 after release writes 4.
